bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with a valid/ready input and a one-cycle result strobe.
// Optional macro BIN_TO_BCD_BLANK_EN replaces leading zero digits with 4'hF.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 7,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [BIN_W-1:0]      bin_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic                  valid_o
);

    localparam int unsigned MIN_DIGITS = (BIN_W + 2) / 3;
    localparam int unsigned INT_DIGITS = (DIGITS > MIN_DIGITS) ? DIGITS : MIN_DIGITS;
    localparam int unsigned INT_W      = 4 * INT_DIGITS;
    localparam int unsigned OUT_W      = 4 * DIGITS;
    localparam int unsigned CNT_W      = (BIN_W > 2) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [INT_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [INT_W-1:0]   bcd_adj;
    logic [OUT_W-1:0]   blank_c;
    logic               ovf_c;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (valid_i) state_d = S_CONV;
            S_CONV: if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == S_IDLE);
    end

    // Every digit is corrected from the pre-shift value before the whole register shifts.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < INT_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        ovf_c = 1'b0;
        for (int unsigned i = DIGITS; i < INT_DIGITS; i++) begin
            ovf_c = ovf_c | (|bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        blank_c = bcd_q[OUT_W-1:0];
`ifdef BIN_TO_BCD_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (bcd_q[4*i +: 4] == 4'h0)) begin
                    blank_c[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    bin_d = bin_i;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            S_CONV: begin
                bcd_d = (bcd_adj << 1) | INT_W'(bin_q[BIN_W-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
            end
            S_DONE: begin
                valid_d = 1'b1;
                ovf_d   = ovf_c;
                out_d   = ovf_c ? {DIGITS{4'h9}} : blank_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bcd_o   = out_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;

endmodule
